fm_sb_seq: RTL

Trigger-driven freeze/playback sequencer for the spy buffers.
- Arms on request, waits for a trigger, then applies a programmable post-trigger delay.
- Freezes all unmasked spy buffers, and optionally steps them into playback until released.
- Sits between the FM control registers (AXI domain) and the per-buffer freeze/playback inputs; it replaces static global-freeze driving with a timed, event-based sequence.

---
 rtl/fm_sb_pkg.sv | 19 +
 rtl/fm_sb_seq_if.sv | 44 ++++
 rtl/fm_sb_seq_out.sv | 32 +++
 rtl/fm_sb_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fm_sb_pkg.sv
// Shared constants and types for the FM spy-buffer control blocks.
// Holds the buffer/mode sizing plus the freeze/playback sequencer state encoding.
package fm_sb_pkg;

   localparam int sb_mapped_n   = 64;
   localparam int pb_mode_width = 2;

   localparam int SEQ_DLY_W = 16;
   localparam int SEQ_CNT_W = 16;

   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_ARMED     = 3'd1,
      SEQ_POST_TRIG = 3'd2,
      SEQ_FROZEN    = 3'd3,
      SEQ_PLAYBACK  = 3'd4
   } fm_sb_seq_state_t;

endpackage

// File: rtl/fm_sb_seq_if.sv
// Control/status bundle between the FM register block (master) and the
// freeze/playback sequencer (slave).
interface fm_sb_seq_if
   import fm_sb_pkg::*;
#(
   parameter int SB_N  = sb_mapped_n,
   parameter int PB_W  = pb_mode_width,
   parameter int DLY_W = SEQ_DLY_W,
   parameter int CNT_W = SEQ_CNT_W
);

   logic             arm;
   logic             trigger;
   logic             unfreeze;
   logic             pb_start;
   logic             pb_stop;
   logic [PB_W-1:0]  pb_mode_req;
   logic [DLY_W-1:0] post_trig_dly;
   logic [SB_N-1:0]  freeze_mask;
   logic [SB_N-1:0]  playback_mask;

   logic [SB_N-1:0]  freeze;
   logic [PB_W-1:0]  playback_mode [SB_N];
   logic [2:0]       state;
   logic             busy;
   logic             frozen_pulse;
   logic [CNT_W-1:0] freeze_count;
   logic             timeout;

   modport master (
      output arm, trigger, unfreeze, pb_start, pb_stop,
             pb_mode_req, post_trig_dly, freeze_mask, playback_mask,
      input  freeze, playback_mode, state, busy, frozen_pulse,
             freeze_count, timeout
   );

   modport slave (
      input  arm, trigger, unfreeze, pb_start, pb_stop,
             pb_mode_req, post_trig_dly, freeze_mask, playback_mask,
      output freeze, playback_mode, state, busy, frozen_pulse,
             freeze_count, timeout
   );

endinterface

// File: rtl/fm_sb_seq_out.sv
// Registered mask-apply stage: turns state-qualified enables plus the latched
// masks/mode into the per-buffer freeze and playback_mode outputs.
module fm_sb_seq_out
   import fm_sb_pkg::*;
#(
   parameter int SB_N = sb_mapped_n,
   parameter int PB_W = pb_mode_width
) (
   input  logic            axi_clk,
   input  logic            axi_rst,
   input  logic            frz_en,
   input  logic            pb_en,
   input  logic [SB_N-1:0] freeze_mask_l,
   input  logic [SB_N-1:0] playback_mask_l,
   input  logic [PB_W-1:0] mode_l,
   output logic [SB_N-1:0] freeze,
   output logic [PB_W-1:0] playback_mode [SB_N]
);

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         freeze <= '0;
         // NOTE: this array is a bank of output flops, not a RAM, so it is reset like any other output.
         for (int i = 0; i < SB_N; i++) playback_mode[i] <= '0;
      end else begin
         freeze <= frz_en ? ~freeze_mask_l : '0;
         for (int i = 0; i < SB_N; i++)
            playback_mode[i] <= (pb_en && !playback_mask_l[i]) ? mode_l : '0;
      end
   end

endmodule

// File: rtl/fm_sb_seq.sv
// Trigger-driven freeze/playback sequencer for the spy buffers.
// Define FM_SB_SEQ_TIMEOUT_EN to let ARMED give up after ARM_TIMEOUT cycles.
module fm_sb_seq
   import fm_sb_pkg::*;
#(
   parameter int SB_N  = sb_mapped_n,
   parameter int PB_W  = pb_mode_width,
   parameter int DLY_W = SEQ_DLY_W,
   parameter int CNT_W = SEQ_CNT_W
`ifdef FM_SB_SEQ_TIMEOUT_EN
   ,
   parameter int ARM_TIMEOUT = 1000000
`endif
) (
   input logic        axi_clk,
   input logic        axi_rst,
   fm_sb_seq_if.slave sb
);

   fm_sb_seq_state_t state_q, state_d;

   logic [DLY_W-1:0] dly_l;
   logic [DLY_W-1:0] cnt_q;
   logic [SB_N-1:0]  freeze_mask_l;
   logic [SB_N-1:0]  playback_mask_l;
   logic [PB_W-1:0]  mode_l;
   logic             first_q;
   logic             frozen_pulse_q;
   logic [CNT_W-1:0] freeze_count_q;
   logic             tmo_hit;
   logic             frz_en;
   logic             pb_en;

   // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      if (sb.unfreeze) begin
         state_d = SEQ_IDLE;
      end else begin
         case (state_q)
            SEQ_IDLE:      if (sb.arm) state_d = SEQ_ARMED;
            SEQ_ARMED: begin
               if (sb.trigger)
                  state_d = (dly_l == '0) ? SEQ_FROZEN : SEQ_POST_TRIG;
               else if (tmo_hit)
                  state_d = SEQ_IDLE;
            end
            SEQ_POST_TRIG: if (cnt_q == DLY_W'(1)) state_d = SEQ_FROZEN;
            SEQ_FROZEN:    if (sb.pb_start) state_d = SEQ_PLAYBACK;
            SEQ_PLAYBACK:  if (sb.pb_stop) state_d = SEQ_FROZEN;
            default:       state_d = SEQ_IDLE;
         endcase
      end
   end

   // Outputs follow the state one edge late, and drop on the same edge that leaves FROZEN/PLAYBACK.
   assign frz_en = (state_q == SEQ_FROZEN || state_q == SEQ_PLAYBACK) &&
                   (state_d == SEQ_FROZEN || state_d == SEQ_PLAYBACK);
   assign pb_en  = (state_q == SEQ_PLAYBACK) && (state_d == SEQ_PLAYBACK);

   // NOTE: all sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         state_q         <= SEQ_IDLE;
         dly_l           <= '0;
         cnt_q           <= '0;
         freeze_mask_l   <= '0;
         playback_mask_l <= '0;
         mode_l          <= '0;
         first_q         <= 1'b0;
         frozen_pulse_q  <= 1'b0;
         freeze_count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == SEQ_IDLE && state_d == SEQ_ARMED) begin
            dly_l           <= sb.post_trig_dly;
            freeze_mask_l   <= sb.freeze_mask;
            playback_mask_l <= sb.playback_mask;
         end
         if (state_q == SEQ_FROZEN && state_d == SEQ_PLAYBACK)
            mode_l <= sb.pb_mode_req;
         if (state_q == SEQ_ARMED && state_d == SEQ_POST_TRIG)
            cnt_q <= dly_l;
         else if (state_d == SEQ_POST_TRIG)
            cnt_q <= cnt_q - DLY_W'(1);
         // Only a trigger-driven entry counts; returning from PLAYBACK does not.
         first_q        <= (state_d == SEQ_FROZEN) &&
                           (state_q == SEQ_ARMED || state_q == SEQ_POST_TRIG);
         frozen_pulse_q <= first_q && frz_en;
         if (first_q && frz_en && freeze_count_q != '1)
            freeze_count_q <= freeze_count_q + CNT_W'(1);
      end
   end

`ifdef FM_SB_SEQ_TIMEOUT_EN
   localparam int TMO_W = (ARM_TIMEOUT > 2) ? $clog2(ARM_TIMEOUT) : 1;

   logic [TMO_W-1:0] tmo_q;
   logic             timeout_q;

   assign tmo_hit = (state_q == SEQ_ARMED) && (tmo_q == TMO_W'(ARM_TIMEOUT - 1));

   // Counter idles at zero outside ARMED, so it starts from zero on every entry.
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_hit && !sb.trigger && !sb.unfreeze;
         tmo_q     <= (state_q == SEQ_ARMED) ? tmo_q + TMO_W'(1) : '0;
      end
   end

   assign sb.timeout = timeout_q;
`else
   assign tmo_hit    = 1'b0;
   assign sb.timeout = 1'b0;
`endif

   fm_sb_seq_out #(
      .SB_N (SB_N),
      .PB_W (PB_W)
   ) u_out (
      .axi_clk         (axi_clk),
      .axi_rst         (axi_rst),
      .frz_en          (frz_en),
      .pb_en           (pb_en),
      .freeze_mask_l   (freeze_mask_l),
      .playback_mask_l (playback_mask_l),
      .mode_l          (mode_l),
      .freeze          (sb.freeze),
      .playback_mode   (sb.playback_mode)
   );

   assign sb.state        = state_q;
   assign sb.busy         = (state_q != SEQ_IDLE);
   assign sb.frozen_pulse = frozen_pulse_q;
   assign sb.freeze_count = freeze_count_q;

endmodule
